ofmap_writer: RTL

Output-write stage of the accelerator datapath. Accepts 4-lane fp16 result vectors from the GELU stage, buffers them in a small FIFO and serializes them into 32-bit word writes to the 8k×32b output SRAM at a running address. It counts stored elements against a programmed total and raises `done` when the output feature map is complete, so the ICB slave's DONE register can read back a finished result.

---
 rtl/ofmap_writer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ofmap_writer.sv
// Output-write stage: buffers 4-lane fp16 vectors and serializes them into 32-bit SRAM word writes.
// Define OFMAP_PACK_EN for packed mode (two fp16 per word); default build writes one zero-extended fp16 per word.
module ofmap_writer #(
    parameter int LANES      = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int ADDR_W     = 13
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [12:0]           total_cnt,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*16-1:0]   in_data,
    output logic                  sram_wr_en,
    output logic [ADDR_W-1:0]     sram_wr_addr,
    output logic [31:0]           sram_wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  drop_err
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
`ifdef OFMAP_PACK_EN
    localparam int WPV = LANES / 2;
`else
    localparam int WPV = LANES;
`endif
    localparam int IDX_W = (WPV > 1) ? $clog2(WPV) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WPV - 1);
    localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t state, state_nxt;

    logic [LANES-1:0][15:0] fifo_mem [FIFO_DEPTH];
    logic [LANES-1:0][15:0] head_lanes;
    logic [PTR_W-1:0]       rd_ptr, wr_ptr;
    logic [PTR_W:0]         occ, occ_nxt;
    logic [IDX_W-1:0]       word_idx;
    logic [12:0]            elem_cnt, total_q, step;
    logic [ADDR_W-1:0]      addr_ptr;
    logic [31:0]            word_data;
    logic                   push, pop, engine_go, last_word, flush;

    assign head_lanes = fifo_mem[rd_ptr];
    assign push       = in_valid && in_ready;
    assign engine_go  = (state == S_RUN) && !start && (occ != '0) && (elem_cnt != total_q);
    assign last_word  = (word_idx == LAST_IDX);
    assign pop        = engine_go && last_word;
    // Leaving RUN for DONE discards any vector lanes beyond total_cnt.
    assign flush      = start || ((state == S_RUN) && (state_nxt == S_DONE));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (!start && (elem_cnt == total_q)) state_nxt = S_DONE;
            S_DONE:  if (start) state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef OFMAP_PACK_EN
    logic [12:0] remaining;
    assign remaining = total_q - elem_cnt;
    // An odd tail leaves the upper half of the final word zero.
    always_comb begin
        word_data = {head_lanes[{word_idx, 1'b1}], head_lanes[{word_idx, 1'b0}]};
        step      = 13'd2;
        if (remaining == 13'd1) begin
            word_data[31:16] = 16'h0;
            step             = 13'd1;
        end
    end
`else
    always_comb begin
        word_data = {16'h0, head_lanes[word_idx]};
        step      = 13'd1;
    end
`endif

    always_comb begin
        occ_nxt = occ;
        if (flush)
            occ_nxt = '0;
        else if (push && !pop)
            occ_nxt = occ + 1'b1;
        else if (pop && !push)
            occ_nxt = occ - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            occ          <= '0;
            word_idx     <= '0;
            elem_cnt     <= '0;
            total_q      <= '0;
            addr_ptr     <= '0;
            in_ready     <= 1'b0;
            sram_wr_en   <= 1'b0;
            sram_wr_addr <= '0;
            sram_wr_data <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            drop_err     <= 1'b0;
        end else begin
            state    <= state_nxt;
            occ      <= occ_nxt;
            in_ready <= (state_nxt == S_RUN) && (occ_nxt < DEPTH_C);
            busy     <= (state_nxt == S_RUN);
            done     <= (state_nxt == S_DONE);
            sram_wr_en <= engine_go;

            if (engine_go) begin
                sram_wr_addr <= addr_ptr;
                sram_wr_data <= word_data;
                addr_ptr     <= addr_ptr + 1'b1;
                elem_cnt     <= elem_cnt + step;
                word_idx     <= last_word ? '0 : word_idx + 1'b1;
            end

            if (flush) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                word_idx <= '0;
            end else begin
                if (push) begin
                    fifo_mem[wr_ptr] <= in_data;
                    wr_ptr           <= wr_ptr + 1'b1;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
            end

            if (start) begin
                total_q  <= total_cnt;
                addr_ptr <= base_addr;
                elem_cnt <= '0;
                drop_err <= 1'b0;
            end else if (in_valid && (state != S_RUN)) begin
                drop_err <= 1'b1;
            end
        end
    end
endmodule
